// File: rtl/riscv_mc_pkg.sv
// Shared constants for the multicycle RISC-V control unit: state codes,
// opcodes, ALUOp and ALUControl encodings.
package riscv_mc_pkg;

  localparam int XLEN_OP   = 7;
  localparam int ALUCTRL_W = 3;

  typedef logic [3:0] statetype;

  localparam statetype FETCH    = 4'd0;
  localparam statetype DECODE   = 4'd1;
  localparam statetype MEMADR   = 4'd2;
  localparam statetype MEMREAD  = 4'd3;
  localparam statetype MEMWB    = 4'd4;
  localparam statetype MEMWRITE = 4'd5;
  localparam statetype EXECUTER = 4'd6;
  localparam statetype EXECUTEI = 4'd7;
  localparam statetype ALUWB    = 4'd8;
  localparam statetype BEQ      = 4'd9;
  localparam statetype JAL      = 4'd10;

  localparam logic [XLEN_OP-1:0] OP_LW  = 7'b0000011;
  localparam logic [XLEN_OP-1:0] OP_SW  = 7'b0100011;
  localparam logic [XLEN_OP-1:0] OP_R   = 7'b0110011;
  localparam logic [XLEN_OP-1:0] OP_I   = 7'b0010011;
  localparam logic [XLEN_OP-1:0] OP_BEQ = 7'b1100011;
  localparam logic [XLEN_OP-1:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;

  function automatic logic is_supported(input logic [XLEN_OP-1:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/aludec.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to ALUControl.
module aludec
  import riscv_mc_pkg::*;
(
  input  logic                 op5,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic [1:0]           aluop,
  output logic [ALUCTRL_W-1:0] alucontrol
);

  // ALU operation select; only R-type with funct7b5 set turns funct3=000 into sub
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000: begin
            if (op5 & funct7b5) alucontrol = ALU_SUB;
            else                alucontrol = ALU_ADD;
          end
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_fsm.sv
// Moore sequencer for the multicycle datapath: state register, next-state
// logic and per-state control decode. Write enables are held low during reset.
module mc_fsm
  import riscv_mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN_OP-1:0] op,
  input  logic               memready,
  output logic               adrsrc,
  output logic               memwrite,
  output logic               irwrite,
  output logic [1:0]         resultsrc,
  output logic [1:0]         alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               regwrite,
  output logic               pcupdate,
  output logic               branch,
  output logic               illegalinstr
);

  statetype state_r;
  statetype next_state_s;
  logic     memwrite_s;
  logic     irwrite_s;
  logic     regwrite_s;
  logic     pcupdate_s;
  logic     branch_s;
  logic     illegal_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= FETCH;
    else       state_r <= next_state_s;
  end

  // Next-state selection
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH: begin
        if (memready) next_state_s = DECODE;
        else          next_state_s = FETCH;
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_R:         next_state_s = EXECUTER;
          OP_I:         next_state_s = EXECUTEI;
          OP_BEQ:       next_state_s = BEQ;
          OP_JAL:       next_state_s = JAL;
          default:      next_state_s = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW) next_state_s = MEMREAD;
        else             next_state_s = MEMWRITE;
      end
      MEMREAD: begin
        if (memready) next_state_s = MEMWB;
        else          next_state_s = MEMREAD;
      end
      MEMWRITE: begin
        if (memready) next_state_s = FETCH;
        else          next_state_s = MEMWRITE;
      end
      EXECUTER: next_state_s = ALUWB;
      EXECUTEI: next_state_s = ALUWB;
      JAL:      next_state_s = ALUWB;
      MEMWB:    next_state_s = FETCH;
      ALUWB:    next_state_s = FETCH;
      BEQ:      next_state_s = FETCH;
      default:  next_state_s = FETCH;
    endcase
  end

  // Per-state control decode; anything not set below stays at zero
  always_comb begin
    adrsrc     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = ALUOP_ADD;
    regwrite_s = 1'b0;
    pcupdate_s = 1'b0;
    branch_s   = 1'b0;
    illegal_s  = 1'b0;
    case (state_r)
      FETCH: begin
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        irwrite_s  = memready;
        pcupdate_s = memready;
      end
      DECODE: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b01;
        illegal_s = ~is_supported(op);
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD: adrsrc = 1'b1;
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNC;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNC;
      end
      ALUWB: regwrite_s = 1'b1;
      BEQ: begin
        alusrca  = 2'b10;
        aluop    = ALUOP_SUB;
        branch_s = 1'b1;
      end
      JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcupdate_s = 1'b1;
      end
      default: begin
        adrsrc = 1'b0;
      end
    endcase
  end

  assign memwrite     = memwrite_s & ~reset;
  assign irwrite      = irwrite_s  & ~reset;
  assign regwrite     = regwrite_s & ~reset;
  assign pcupdate     = pcupdate_s & ~reset;
  assign branch       = branch_s   & ~reset;
  assign illegalinstr = illegal_s  & ~reset;

endmodule

// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RISC-V datapath: sequencer, ALU decoder,
// immediate-format decode and PC write enable.
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN_OP-1:0]   op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 IllegalInstr
);

  logic [1:0] aluop_s;
  logic       pcupdate_s;
  logic       branch_s;

  mc_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .memready     (MemReady),
    .adrsrc       (AdrSrc),
    .memwrite     (MemWrite),
    .irwrite      (IRWrite),
    .resultsrc    (ResultSrc),
    .alusrca      (ALUSrcA),
    .alusrcb      (ALUSrcB),
    .aluop        (aluop_s),
    .regwrite     (RegWrite),
    .pcupdate     (pcupdate_s),
    .branch       (branch_s),
    .illegalinstr (IllegalInstr)
  );

  aludec u_aludec (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (aluop_s),
    .alucontrol (ALUControl)
  );

  // Immediate format from opcode; unsupported opcodes fall back to I-type
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite = pcupdate_s | (branch_s & Zero);

endmodule
